// File: rtl/ysyx_22041461_ex_mem_pkg.sv
// rtl/ysyx_22041461_ex_mem_pkg.sv - shared constants and types for the EX->MEM stage
// Contents:
//   XLEN, MEMOP_W    default datapath and memory-op widths
//   memop_e          memory-operation codes carried to MEM
//   occ_e            skid buffer occupancy states
//   payload_width()  packed width of one stage entry
package ysyx_22041461_ex_mem_pkg;

  localparam int XLEN    = 64;
  localparam int MEMOP_W = 4;

  typedef enum logic [MEMOP_W-1:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LH   = 4'd2,
    MEMOP_LW   = 4'd3,
    MEMOP_LD   = 4'd4,
    MEMOP_LBU  = 4'd5,
    MEMOP_LHU  = 4'd6,
    MEMOP_LWU  = 4'd7,
    MEMOP_SB   = 4'd8,
    MEMOP_SH   = 4'd9,
    MEMOP_SW   = 4'd10,
    MEMOP_SD   = 4'd11
  } memop_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_e;

  // pc + alu_out + store_data + rd(5) + reg_wen(1) + mem_op
  function automatic int payload_width(input int xlen, input int memop_w);
    return 3 * xlen + 5 + 1 + memop_w;
  endfunction

endpackage

// File: rtl/ysyx_22041461_ex_mem_if.sv
// rtl/ysyx_22041461_ex_mem_if.sv - EX->MEM stage handshake and payload bundle
// Signals:
//   in_valid/in_ready + in_* payload     EX side (upstream)
//   out_valid/out_ready + out_* payload  MEM side (downstream)
// Modports:
//   master  environment around the stage (drives EX side, consumes MEM side)
//   slave   the stage itself
interface ysyx_22041461_ex_mem_if #(
  parameter int XLEN    = ysyx_22041461_ex_mem_pkg::XLEN,
  parameter int MEMOP_W = ysyx_22041461_ex_mem_pkg::MEMOP_W
);

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [XLEN-1:0]    in_alu_out;
  logic [XLEN-1:0]    in_store_data;
  logic [4:0]         in_rd;
  logic               in_reg_wen;
  logic [MEMOP_W-1:0] in_mem_op;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    out_alu_out;
  logic [XLEN-1:0]    out_store_data;
  logic [4:0]         out_rd;
  logic               out_reg_wen;
  logic [MEMOP_W-1:0] out_mem_op;

  modport master (
    output in_valid, in_pc, in_alu_out, in_store_data, in_rd, in_reg_wen, in_mem_op,
    output out_ready,
    input  in_ready,
    input  out_valid, out_pc, out_alu_out, out_store_data, out_rd, out_reg_wen, out_mem_op
  );

  modport slave (
    input  in_valid, in_pc, in_alu_out, in_store_data, in_rd, in_reg_wen, in_mem_op,
    input  out_ready,
    output in_ready,
    output out_valid, out_pc, out_alu_out, out_store_data, out_rd, out_reg_wen, out_mem_op
  );

endinterface

// File: rtl/ysyx_22041461_skid_buf.sv
// rtl/ysyx_22041461_skid_buf.sv - generic 2-entry skid buffer with registered in_ready
// Ports:
//   clk, rst                 clock, async active-high reset
//   flush_i                  drop every held entry on the next edge
//   in_valid_i/in_ready_o    upstream handshake (in_ready_o is a flop)
//   in_data_i                upstream payload
//   out_valid_o/out_ready_i  downstream handshake
//   out_data_o               head-of-queue payload (main entry)
module ysyx_22041461_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  import ysyx_22041461_ex_mem_pkg::*;

  occ_e         state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc, rel;

  assign acc = in_valid_i & in_ready_q;
  assign rel = (state_q != ST_EMPTY) & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_ONE;
          main_d  = in_data_i;
        end
      end
      ST_ONE: begin
        if (acc && rel) begin
          main_d = in_data_i;
        end else if (acc) begin
          state_d = ST_TWO;
          skid_d  = in_data_i;
        end else if (rel) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (rel) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything; stale payload is harmless because
    // out_valid is decoded from the state alone.
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    // in_ready is decoded from the next state so it lands in a flop and
    // never sees out_ready combinationally.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;

endmodule

// File: rtl/ysyx_22041461_ex_mem.sv
// rtl/ysyx_22041461_ex_mem.sv - EX->MEM pipeline register with 2-entry skid buffering
// Ports:
//   clk, rst   clock, async active-high reset
//   flush      squash held instructions on redirect/trap
//   bus        slave side of the EX->MEM bundle (in_* from EX, out_* to MEM)
module ysyx_22041461_ex_mem #(
  parameter int XLEN    = ysyx_22041461_ex_mem_pkg::XLEN,
  parameter int MEMOP_W = ysyx_22041461_ex_mem_pkg::MEMOP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ysyx_22041461_ex_mem_if.slave  bus
);
  import ysyx_22041461_ex_mem_pkg::*;

  localparam int PW = payload_width(XLEN, MEMOP_W);

  logic [PW-1:0]      in_data;
  logic [PW-1:0]      out_data;
  logic               out_valid;
  logic               out_wen_raw;
  logic [MEMOP_W-1:0] out_op_raw;

  assign in_data = {bus.in_pc, bus.in_alu_out, bus.in_store_data,
                    bus.in_rd, bus.in_reg_wen, bus.in_mem_op};

  ysyx_22041461_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (out_data)
  );

  assign {bus.out_pc, bus.out_alu_out, bus.out_store_data,
          bus.out_rd, out_wen_raw, out_op_raw} = out_data;

  // Side-effect controls are masked on bubbles so stale payload left behind
  // by a drain or flush can never trigger a write or memory access.
  assign bus.out_valid   = out_valid;
  assign bus.out_reg_wen = out_valid & out_wen_raw;
  assign bus.out_mem_op  = out_valid ? out_op_raw : '0;

endmodule

// File: tb/tb_ysyx_22041461_ex_mem.sv
// tb/tb_ysyx_22041461_ex_mem.sv - self-checking bench for ysyx_22041461_ex_mem
module tb_ysyx_22041461_ex_mem;
  import ysyx_22041461_ex_mem_pkg::*;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        wen;
    logic [3:0]  op;
  } pay_t;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    pay_t        p;
    logic        e_ov;
    logic        e_ir;
    logic [63:0] e_pc;
    logic [63:0] e_alu;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic [3:0]  e_op;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];
  pay_t mq[$];

  always #5 clk = ~clk;

  ysyx_22041461_ex_mem_if #(.XLEN(64), .MEMOP_W(4)) bus ();

  ysyx_22041461_ex_mem #(.XLEN(64), .MEMOP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic pay_t mk(input logic [63:0] pc, input logic [63:0] alu,
                              input logic [4:0] rd, input logic wen, input logic [3:0] op);
    pay_t p;
    p.pc = pc; p.alu = alu; p.sd = ~alu; p.rd = rd; p.wen = wen; p.op = op;
    return p;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic ordy, input pay_t p);
    flush             = fl;
    bus.in_valid      = iv;
    bus.out_ready     = ordy;
    bus.in_pc         = p.pc;
    bus.in_alu_out    = p.alu;
    bus.in_store_data = p.sd;
    bus.in_rd         = p.rd;
    bus.in_reg_wen    = p.wen;
    bus.in_mem_op     = p.op;
  endtask

  task automatic add_vec(input logic fl, input logic iv, input logic ordy, input pay_t p,
                         input logic e_ov, input logic e_ir, input logic [63:0] e_pc,
                         input logic [63:0] e_alu, input logic [4:0] e_rd,
                         input logic e_wen, input logic [3:0] e_op);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.p = p;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc; v.e_alu = e_alu;
    v.e_rd = e_rd; v.e_wen = e_wen; v.e_op = e_op;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, mk(64'h0, 64'h0, 5'd0, 1'b0, 4'd0));
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'h0);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'h1);
    chk({tag, ".out_pc"}, bus.out_pc, 64'h0);
    chk({tag, ".out_alu_out"}, bus.out_alu_out, 64'h0);
    chk({tag, ".out_store_data"}, bus.out_store_data, 64'h0);
    chk({tag, ".out_rd"}, 64'(bus.out_rd), 64'h0);
    chk({tag, ".out_reg_wen"}, 64'(bus.out_reg_wen), 64'h0);
    chk({tag, ".out_mem_op"}, 64'(bus.out_mem_op), 64'h0);
  endtask

  // Reference: the stage is a FIFO of depth 2 whose accept permission comes
  // from the occupancy seen before the edge; flush empties it.
  task automatic model_step(input logic fl, input logic iv, input logic ordy, input pay_t p);
    logic can_acc, do_rel;
    if (fl) begin
      mq.delete();
    end else begin
      can_acc = iv && (mq.size() < 2);
      do_rel  = ordy && (mq.size() > 0);
      if (do_rel) void'(mq.pop_front());
      if (can_acc) mq.push_back(p);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(mq.size() > 0));
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk({tag, ".out_pc"}, bus.out_pc, mq[0].pc);
      chk({tag, ".out_alu_out"}, bus.out_alu_out, mq[0].alu);
      chk({tag, ".out_store_data"}, bus.out_store_data, mq[0].sd);
      chk({tag, ".out_rd"}, 64'(bus.out_rd), 64'(mq[0].rd));
      chk({tag, ".out_reg_wen"}, 64'(bus.out_reg_wen), 64'(mq[0].wen));
      chk({tag, ".out_mem_op"}, 64'(bus.out_mem_op), 64'(mq[0].op));
    end else begin
      chk({tag, ".out_reg_wen"}, 64'(bus.out_reg_wen), 64'h0);
      chk({tag, ".out_mem_op"}, 64'(bus.out_mem_op), 64'h0);
    end
  endtask

  initial begin
    pay_t pa, pb, pc_, pd, pe, pf, pg, pz, pr;
    logic fl, iv, ordy;

    rst = 1'b1;
    pz  = mk(64'h0, 64'h0, 5'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, pz);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    pa  = mk(64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 5'd5, 1'b1, MEMOP_NONE);
    pb  = mk(64'h8000_0004, 64'h0000_0000_0000_0001, 5'd6, 1'b1, MEMOP_SD);
    pc_ = mk(64'h8000_0008, 64'h0000_0000_0000_0002, 5'd7, 1'b1, MEMOP_LW);
    pd  = mk(64'h8000_0010, 64'h1234_5678_9ABC_DEF0, 5'd7, 1'b1, MEMOP_LD);
    pe  = mk(64'h8000_0014, 64'h0000_0000_0000_0003, 5'd8, 1'b1, MEMOP_LB);
    pf  = mk(64'h8000_0018, 64'h0000_0000_0000_0004, 5'd9, 1'b1, MEMOP_SW);
    pg  = mk(64'h8000_0020, 64'hDEAD_BEEF_0000_0000, 5'd0, 1'b0, MEMOP_SH);

    //      fl    iv    rdy   in   ov    ir    pc              alu                    rd     wen   op
    add_vec(1'b0, 1'b1, 1'b1, pa,  1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 5'd5, 1'b1, 4'd0);
    add_vec(1'b0, 1'b1, 1'b0, pb,  1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 5'd5, 1'b1, 4'd0);
    add_vec(1'b0, 1'b1, 1'b0, pc_, 1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 5'd5, 1'b1, 4'd0);
    add_vec(1'b0, 1'b0, 1'b1, pz,  1'b1, 1'b1, 64'h8000_0004, 64'h0000_0000_0000_0001, 5'd6, 1'b1, 4'd11);
    add_vec(1'b0, 1'b0, 1'b1, pz,  1'b0, 1'b1, 64'h0,         64'h0,                   5'd0, 1'b0, 4'd0);
    add_vec(1'b0, 1'b1, 1'b0, pd,  1'b1, 1'b1, 64'h8000_0010, 64'h1234_5678_9ABC_DEF0, 5'd7, 1'b1, 4'd4);
    add_vec(1'b0, 1'b1, 1'b0, pe,  1'b1, 1'b0, 64'h8000_0010, 64'h1234_5678_9ABC_DEF0, 5'd7, 1'b1, 4'd4);
    add_vec(1'b1, 1'b1, 1'b0, pf,  1'b0, 1'b1, 64'h0,         64'h0,                   5'd0, 1'b0, 4'd0);
    add_vec(1'b0, 1'b0, 1'b1, pz,  1'b0, 1'b1, 64'h0,         64'h0,                   5'd0, 1'b0, 4'd0);
    add_vec(1'b0, 1'b1, 1'b1, pg,  1'b1, 1'b1, 64'h8000_0020, 64'hDEAD_BEEF_0000_0000, 5'd0, 1'b0, 4'd8 + 4'd1);
    add_vec(1'b1, 1'b0, 1'b0, pz,  1'b0, 1'b1, 64'h0,         64'h0,                   5'd0, 1'b0, 4'd0);

    foreach (vq[i]) begin
      drive(vq[i].fl, vq[i].iv, vq[i].ordy, vq[i].p);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.out_valid", i), 64'(bus.out_valid), 64'(vq[i].e_ov));
      chk($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(vq[i].e_ir));
      chk($sformatf("vec%0d.out_reg_wen", i), 64'(bus.out_reg_wen), 64'(vq[i].e_wen));
      chk($sformatf("vec%0d.out_mem_op", i), 64'(bus.out_mem_op), 64'(vq[i].e_op));
      if (vq[i].e_ov) begin
        chk($sformatf("vec%0d.out_pc", i), bus.out_pc, vq[i].e_pc);
        chk($sformatf("vec%0d.out_alu_out", i), bus.out_alu_out, vq[i].e_alu);
        chk($sformatf("vec%0d.out_store_data", i), bus.out_store_data, ~vq[i].e_alu);
        chk($sformatf("vec%0d.out_rd", i), 64'(bus.out_rd), 64'(vq[i].e_rd));
      end
    end

    // Streaming: eight back-to-back instructions, no bubbles
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, mk(64'h1000 + 64'(4 * i), 64'(i), 5'(i + 1), 1'b1, MEMOP_LW));
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d.out_valid", i), 64'(bus.out_valid), 64'h1);
      chk($sformatf("stream%0d.out_pc", i), bus.out_pc, 64'h1000 + 64'(4 * i));
      chk($sformatf("stream%0d.in_ready", i), 64'(bus.in_ready), 64'h1);
    end
    drive(1'b0, 1'b0, 1'b1, pz);
    @(posedge clk);
    #1;
    chk("stream_drain.out_valid", 64'(bus.out_valid), 64'h0);

    // Asynchronous reset between edges while one entry is held
    do_reset();
    drive(1'b0, 1'b1, 1'b0, pd);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, pz);
    chk("areset_pre.out_valid", 64'(bus.out_valid), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("areset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("areset_post.out_valid", 64'(bus.out_valid), 64'h0);

    // Randomized traffic against the FIFO reference
    do_reset();
    for (int n = 0; n < 600; n++) begin
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      pr   = mk({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)));
      pr.sd = {$urandom, $urandom};
      drive(fl, iv, ordy, pr);
      @(posedge clk);
      model_step(fl, iv, ordy, pr);
      #1;
      check_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
